cache_ctrl: RTL and testbench

- Sequencing controller for the set-associative cache tag store.
- Accepts one read/write request at a time and performs tag lookup against all ways of the indexed set.
- On a miss, picks a victim by true LRU, writes back the victim if dirty, then refills from main memory over a request/done handshake.
- Maintains valid/dirty/tag/LRU state and hit/miss/writeback statistics counters.
- Sits between the request source (trace driver or CPU port) and the main-memory model.

---
 rtl/cache_pkg.sv | 52 +++++
 rtl/cache_lru.sv | 50 +++++
 rtl/cache_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache tag-store controller:
//   - address field widths and the block-address width
//   - FSM state encoding (plain localparam constants)
//   - LRU rank width and the per-set rank reset pattern
//   - address split helpers: tag_of, index_of, blk_addr
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int ADD_SZ     = 26;
  localparam int TAG_SZ     = 11;
  localparam int IND_SZ     = 9;
  localparam int BLK_OFF_SZ = 6;
  localparam int A          = 4;
  localparam int N_SETS     = 1 << IND_SZ;
  localparam int RANK_W     = $clog2(A);
  localparam int BLK_SZ     = ADD_SZ - BLK_OFF_SZ;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_WB_REQ  = 3'd2;
  localparam logic [2:0] S_WB_WAIT = 3'd3;
  localparam logic [2:0] S_RF_REQ  = 3'd4;
  localparam logic [2:0] S_RF_WAIT = 3'd5;
  localparam logic [2:0] S_UPDATE  = 3'd6;

  // Reset rank pattern for one set: way i holds rank i.
  function automatic logic [A-1:0][RANK_W-1:0] rank_init();
    logic [A-1:0][RANK_W-1:0] r;
    for (int i = 0; i < A; i++) r[i] = RANK_W'(i);
    return r;
  endfunction

  localparam logic [A-1:0][RANK_W-1:0] RANK_RST = rank_init();

  // Shift-and-truncate keeps the whole address in the expression, so the
  // block-offset bits never appear as dangling unused bits.
  function automatic logic [TAG_SZ-1:0] tag_of(input logic [ADD_SZ-1:0] addr);
    return TAG_SZ'(addr >> (ADD_SZ - TAG_SZ));
  endfunction

  function automatic logic [IND_SZ-1:0] index_of(input logic [ADD_SZ-1:0] addr);
    return IND_SZ'(addr >> BLK_OFF_SZ);
  endfunction

  function automatic logic [BLK_SZ-1:0] blk_addr(input logic [TAG_SZ-1:0] tag,
                                                 input logic [IND_SZ-1:0] idx);
    return {tag, idx};
  endfunction

endpackage

// File: rtl/cache_lru.sv
// -----------------------------------------------------------------------------
// cache_lru
// Purely combinational true-LRU helper for one set.
//   i_rank     : current rank of each way (0 = MRU, A-1 = LRU)
//   i_valid    : valid bit of each way
//   i_acc_way  : way being accessed (hit way or refilled victim)
//   o_rank_nxt : ranks after the access; accessed way becomes 0 and every way
//                that was more recent than it ages by one
//   o_victim   : lowest-index invalid way, else the way holding rank A-1
// -----------------------------------------------------------------------------
module cache_lru
  import cache_pkg::*;
(
  input  logic [A-1:0][RANK_W-1:0] i_rank,
  input  logic [A-1:0]             i_valid,
  input  logic [RANK_W-1:0]        i_acc_way,
  output logic [A-1:0][RANK_W-1:0] o_rank_nxt,
  output logic [RANK_W-1:0]        o_victim
);

  logic [RANK_W-1:0] w_acc_rank;
  logic [RANK_W-1:0] w_lru_way;

  assign w_acc_rank = i_rank[i_acc_way];

  // Ranks stay a permutation: only ranks below the accessed one shift up.
  always_comb begin
    o_rank_nxt = i_rank;
    for (int w = 0; w < A; w++) begin
      if (RANK_W'(w) == i_acc_way) begin
        o_rank_nxt[w] = '0;
      end else if (i_rank[w] < w_acc_rank) begin
        o_rank_nxt[w] = i_rank[w] + 1'b1;
      end
    end
  end

  always_comb begin
    w_lru_way = '0;
    for (int w = 0; w < A; w++) begin
      if (i_rank[w] == RANK_W'(A - 1)) w_lru_way = RANK_W'(w);
    end
    // Scan downwards so the last assignment is the lowest invalid way.
    o_victim = w_lru_way;
    for (int w = A - 1; w >= 0; w--) begin
      if (!i_valid[w]) o_victim = RANK_W'(w);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
// Sequencing controller for a set-associative cache tag store. One request at
// a time: tag lookup, then on a miss an optional dirty-victim writeback and a
// refill from main memory, then tag/valid/dirty/LRU update.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_wr, req_addr request payload
//   resp_valid, resp_hit  one-cycle completion pulse and its hit flag
//   mem_req_valid/ready   memory block-transfer handshake
//   mem_req_wr            1 = writeback, 0 = refill; mem_req_addr = {tag,index}
//   mem_done              one-cycle transfer-finished pulse from memory
//   hit_cnt/miss_cnt/wb_cnt  statistics counters, wrap mod 2^32
//   dbg_state             current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. While valid is high and ready is low, the valid side holds its
// payload stable. mem_done is honoured only in the WB_WAIT/RF_WAIT states.
// -----------------------------------------------------------------------------
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADD_SZ-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wr,
  output logic [BLK_SZ-1:0] mem_req_addr,
  input  logic              mem_done,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt,
  output logic [2:0]        dbg_state
);

  // Control registers
  logic [2:0]        r_state;
  logic              r_wr;
  logic [ADD_SZ-1:0] r_addr;
  logic [RANK_W-1:0] r_vic_way;
  logic [TAG_SZ-1:0] r_vic_tag;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_hit;
  logic              r_mem_req_valid;
  logic              r_mem_req_wr;
  logic [BLK_SZ-1:0] r_mem_req_addr;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;
  logic [31:0]       r_wb_cnt;

  // Tag store: tags need no reset, state bits are packed so reset is a
  // single whole-vector assignment.
  logic [TAG_SZ-1:0]                    r_tag [N_SETS][A];
  logic [N_SETS-1:0][A-1:0]             r_valid;
  logic [N_SETS-1:0][A-1:0]             r_dirty;
  logic [N_SETS-1:0][A-1:0][RANK_W-1:0] r_rank;

  logic [TAG_SZ-1:0]          w_tag;
  logic [IND_SZ-1:0]          w_idx;
  logic [A-1:0]               w_set_valid;
  logic [A-1:0]               w_set_dirty;
  logic [A-1:0][RANK_W-1:0]   w_set_rank;
  logic                       w_hit;
  logic [RANK_W-1:0]          w_hit_way;
  logic [RANK_W-1:0]          w_acc_way;
  logic [A-1:0][RANK_W-1:0]   w_rank_nxt;
  logic [RANK_W-1:0]          w_victim;
  logic [TAG_SZ-1:0]          w_vic_tag;
  logic                       w_vic_dirty;
  logic                       w_accept;
  logic [2:0]                 w_state_nxt;
  logic                       w_resp_nxt;
  logic                       w_resp_hit_nxt;
  logic [BLK_SZ-1:0]          w_mem_addr_nxt;

  assign w_tag       = tag_of(r_addr);
  assign w_idx       = index_of(r_addr);
  assign w_set_valid = r_valid[w_idx];
  assign w_set_dirty = r_dirty[w_idx];
  assign w_set_rank  = r_rank[w_idx];
  assign w_accept    = (r_state == S_IDLE) && req_valid && r_req_ready;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = A - 1; w >= 0; w--) begin
      if (w_set_valid[w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = RANK_W'(w);
      end
    end
  end

  // LOOKUP promotes the hit way; UPDATE promotes the refilled victim.
  assign w_acc_way = (r_state == S_UPDATE) ? r_vic_way : w_hit_way;

  cache_lru u_lru (
    .i_rank     (w_set_rank),
    .i_valid    (w_set_valid),
    .i_acc_way  (w_acc_way),
    .o_rank_nxt (w_rank_nxt),
    .o_victim   (w_victim)
  );

  assign w_vic_tag   = r_tag[w_idx][w_victim];
  assign w_vic_dirty = w_set_valid[w_victim] && w_set_dirty[w_victim];

  always_comb begin
    w_state_nxt    = r_state;
    w_resp_nxt     = 1'b0;
    w_resp_hit_nxt = 1'b0;
    w_mem_addr_nxt = r_mem_req_addr;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_state_nxt    = S_IDLE;
          w_resp_nxt     = 1'b1;
          w_resp_hit_nxt = 1'b1;
        end else if (w_vic_dirty) begin
          w_state_nxt    = S_WB_REQ;
          w_mem_addr_nxt = blk_addr(w_vic_tag, w_idx);
        end else begin
          w_state_nxt    = S_RF_REQ;
          w_mem_addr_nxt = blk_addr(w_tag, w_idx);
        end
      end
      S_WB_REQ: begin
        w_mem_addr_nxt = blk_addr(r_vic_tag, w_idx);
        if (mem_req_ready) w_state_nxt = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        if (mem_done) begin
          w_state_nxt    = S_RF_REQ;
          w_mem_addr_nxt = blk_addr(w_tag, w_idx);
        end
      end
      S_RF_REQ: begin
        if (mem_req_ready) w_state_nxt = S_RF_WAIT;
      end
      S_RF_WAIT: begin
        if (mem_done) w_state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        w_state_nxt = S_IDLE;
        w_resp_nxt  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // All outputs are registered from the next-state decode. req_ready stays
  // low through the response cycle so a new request cannot overlap it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_wr            <= 1'b0;
      r_addr          <= '0;
      r_vic_way       <= '0;
      r_vic_tag       <= '0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_hit      <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_wr    <= 1'b0;
      r_mem_req_addr  <= '0;
      r_hit_cnt       <= '0;
      r_miss_cnt      <= '0;
      r_wb_cnt        <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_req_ready     <= (w_state_nxt == S_IDLE) && !w_resp_nxt;
      r_resp_valid    <= w_resp_nxt;
      r_resp_hit      <= w_resp_hit_nxt;
      r_mem_req_valid <= (w_state_nxt == S_WB_REQ) || (w_state_nxt == S_RF_REQ);
      r_mem_req_wr    <= (w_state_nxt == S_WB_REQ);
      r_mem_req_addr  <= w_mem_addr_nxt;
      if (w_accept) begin
        r_wr   <= req_wr;
        r_addr <= req_addr;
      end
      if (r_state == S_LOOKUP) begin
        if (w_hit) begin
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end else begin
          r_miss_cnt <= r_miss_cnt + 32'd1;
          r_vic_way  <= w_victim;
          r_vic_tag  <= w_vic_tag;
        end
      end
      if ((r_state == S_WB_REQ) && mem_req_ready) r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
      r_rank  <= {N_SETS{RANK_RST}};
    end else begin
      if ((r_state == S_LOOKUP) && w_hit) begin
        r_rank[w_idx] <= w_rank_nxt;
        if (r_wr) r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
      if (r_state == S_UPDATE) begin
        r_rank[w_idx]             <= w_rank_nxt;
        r_valid[w_idx][r_vic_way] <= 1'b1;
        r_dirty[w_idx][r_vic_way] <= r_wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_UPDATE) r_tag[w_idx][r_vic_way] <= w_tag;
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_hit      = r_resp_hit;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_wr    = r_mem_req_wr;
  assign mem_req_addr  = r_mem_req_addr;
  assign hit_cnt       = r_hit_cnt;
  assign miss_cnt      = r_miss_cnt;
  assign wb_cnt        = r_wb_cnt;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl
// Directed bench for cache_ctrl. Each request pushes its expected response
// and expected memory transfers onto queues; the bench pops and compares as
// the controller produces them, acting as the main-memory model meanwhile.
// -----------------------------------------------------------------------------
module tb_cache_ctrl;
  import cache_pkg::*;

  // Clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADD_SZ-1:0] req_addr;
  logic              resp_valid;
  logic              resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wr;
  logic [BLK_SZ-1:0] mem_req_addr;
  logic              mem_done;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
  logic [31:0]       wb_cnt;
  logic [2:0]        dbg_state;

  cache_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_wr    (mem_req_wr),
    .mem_req_addr  (mem_req_addr),
    .mem_done      (mem_done),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .wb_cnt        (wb_cnt),
    .dbg_state     (dbg_state)
  );

  // Scoreboard
  logic [0:0]      exp_q[$];       // expected resp_hit per request
  logic [BLK_SZ:0] mem_exp_q[$];   // expected {mem_req_wr, mem_req_addr}
  int checks = 0;
  int errors = 0;
  int m_hit  = 0;
  int m_miss = 0;
  int m_wb   = 0;
  int cyc;

  function automatic logic [ADD_SZ-1:0] addr_of(input int tag, input int idx);
    logic [TAG_SZ-1:0] t;
    logic [IND_SZ-1:0] i;
    t = TAG_SZ'(tag);
    i = IND_SZ'(idx);
    return {t, i, 6'b0};
  endfunction

  function automatic logic [BLK_SZ-1:0] blk_of(input int tag, input int idx);
    logic [TAG_SZ-1:0] t;
    logic [IND_SZ-1:0] i;
    t = TAG_SZ'(tag);
    i = IND_SZ'(idx);
    return {t, i};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
    check({tag, " hit_cnt"},  hit_cnt,  m_hit);
    check({tag, " miss_cnt"}, miss_cnt, m_miss);
    check({tag, " wb_cnt"},   wb_cnt,   m_wb);
  endtask

  // Driver + memory model for one request. stall > 0 holds mem_req_ready low
  // for that many cycles of the first memory request and fires a stray
  // mem_done while it is still pending.
  task automatic do_req(input string tag, input logic wr, input logic [ADD_SZ-1:0] addr,
                        input logic exp_hit, input logic exp_wb,
                        input logic [BLK_SZ-1:0] wb_blk, input int stall);
    int        n;
    bit        done;
    bit        in_req;
    int        done_cd;
    int        stall_left;
    logic [BLK_SZ:0] cur;
    logic [0:0]      exp_r;

    exp_q.push_back(exp_hit);
    if (exp_hit) begin
      m_hit++;
    end else begin
      m_miss++;
      if (exp_wb) begin
        m_wb++;
        mem_exp_q.push_back({1'b1, wb_blk});
      end
      mem_exp_q.push_back({1'b0, addr[ADD_SZ-1:BLK_OFF_SZ]});
    end

    @(negedge clk);
    req_valid     = 1'b1;
    req_wr        = wr;
    req_addr      = addr;
    mem_req_ready = (stall == 0);
    stall_left    = stall;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " accept"}, req_ready, 1);

    @(negedge clk);
    req_valid = 1'b0;
    n = 1; done = 0; in_req = 0; done_cd = 0; cur = '0;
    while (!done && n < 300) begin
      if (mem_done) mem_done = 1'b0;
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) mem_done = 1'b1;
      end
      if (mem_req_valid) begin
        if (!in_req) begin
          in_req = 1;
          if (mem_exp_q.size() > 0) cur = mem_exp_q.pop_front();
          else cur = 'x;
          check({tag, " mem_req"}, {mem_req_wr, mem_req_addr}, cur);
        end else begin
          check({tag, " mem_req stable"}, {mem_req_wr, mem_req_addr}, cur);
        end
        if (!mem_req_ready) begin
          stall_left--;
          if (stall_left == 2) mem_done = 1'b1;
          if (stall_left <= 0) mem_req_ready = 1'b1;
        end
        if (mem_req_ready) begin
          in_req  = 0;
          done_cd = 3;
        end
      end
      if (resp_valid) begin
        done = 1;
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        check({tag, " resp_hit"}, resp_hit, exp_r);
        check({tag, " ready low in resp"}, req_ready, 0);
        if (exp_hit) check({tag, " hit latency"}, n, 2);
      end
      if (!done) begin
        @(negedge clk);
        n++;
      end
    end
    if (!done) check({tag, " resp timeout"}, 0, 1);
    check({tag, " mem queue drained"}, mem_exp_q.size(), 0);
    mem_exp_q.delete();
    mem_done      = 1'b0;
    mem_req_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    mem_req_ready = 1'b1; mem_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset req_ready", req_ready, 1);
    check("reset resp_valid", resp_valid, 0);
    check("reset mem_req_valid", mem_req_valid, 0);
    check_cnt("reset");
    rst = 1'b0;

    // Test 1: cold miss then hit at index 1
    do_req("t1 rd miss", 0, addr_of(0, 1), 0, 0, '0, 0);
    check("t1 refill blk", 32'(blk_of(0, 1)), 32'h1);
    do_req("t1 rd hit", 0, addr_of(0, 1), 1, 0, '0, 0);
    check("t1 hit_cnt", hit_cnt, 1);
    check("t1 miss_cnt", miss_cnt, 1);

    // Test 2: fill index 1 with writes, evict dirty tag 0
    do_req("t2 wr t0", 1, addr_of(0, 1), 1, 0, '0, 0);
    do_req("t2 wr t1", 1, addr_of(1, 1), 0, 0, '0, 0);
    do_req("t2 wr t2", 1, addr_of(2, 1), 0, 0, '0, 0);
    do_req("t2 wr t3", 1, addr_of(3, 1), 0, 0, '0, 0);
    do_req("t2 rd t4", 0, 26'h0020040, 0, 1, blk_of(0, 1), 0);
    check("t2 wb_cnt", wb_cnt, 1);
    check("t2 miss_cnt", miss_cnt, 5);

    // Test 3: LRU order within index 1
    do_req("t3 rd t0", 0, addr_of(0, 1), 0, 1, blk_of(1, 1), 0);
    do_req("t3 rd t1", 0, addr_of(1, 1), 0, 1, blk_of(2, 1), 0);
    do_req("t3 rd t2", 0, addr_of(2, 1), 0, 1, blk_of(3, 1), 0);
    do_req("t3 rd t3", 0, addr_of(3, 1), 0, 0, '0, 0);
    do_req("t3 rd t0 hit", 0, addr_of(0, 1), 1, 0, '0, 0);
    do_req("t3 rd t5", 0, addr_of(5, 1), 0, 0, '0, 0);
    do_req("t3 rd t1 evicted", 0, addr_of(1, 1), 0, 0, '0, 0);
    do_req("t3 rd t0 kept", 0, addr_of(0, 1), 1, 0, '0, 0);
    check_cnt("t3");

    // Test 4: refill stalled by mem_req_ready with a stray mem_done
    do_req("t4 stall miss", 0, addr_of(9, 5), 0, 0, '0, 5);
    do_req("t4 after stall", 0, addr_of(9, 5), 1, 0, '0, 0);
    check_cnt("t4");

    // Test 5: reset while waiting for refill completion
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = addr_of(7, 7); mem_req_ready = 1'b1;
    check("t5 accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!mem_req_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t5 rf req", {mem_req_wr, mem_req_addr}, {1'b0, blk_of(7, 7)});
    @(negedge clk);
    check("t5 req dropped", mem_req_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_done = 1'b1;
    m_hit = 0; m_miss = 0; m_wb = 0;
    exp_q.delete(); mem_exp_q.delete();
    check("t5 rst mem_req_valid", mem_req_valid, 0);
    check("t5 rst req_ready", req_ready, 1);
    check("t5 rst resp_valid", resp_valid, 0);
    check_cnt("t5 rst");
    @(negedge clk);
    mem_done = 1'b0;
    check("t5 late done resp_valid", resp_valid, 0);
    check("t5 late done req_ready", req_ready, 1);
    do_req("t5 reread", 0, addr_of(7, 7), 0, 0, '0, 0);

    // Test 6: independent sets
    do_req("t6 i1 t0", 0, addr_of(0, 1), 0, 0, '0, 0);
    do_req("t6 i2 t0", 0, addr_of(0, 2), 0, 0, '0, 0);
    do_req("t6 i1 t0 hit", 0, addr_of(0, 1), 1, 0, '0, 0);
    do_req("t6 i2 t0 hit", 0, addr_of(0, 2), 1, 0, '0, 0);
    do_req("t6 i2 t1", 0, addr_of(1, 2), 0, 0, '0, 0);
    do_req("t6 i2 t2", 0, addr_of(2, 2), 0, 0, '0, 0);
    do_req("t6 i2 t3", 0, addr_of(3, 2), 0, 0, '0, 0);
    do_req("t6 i1 t1", 0, addr_of(1, 1), 0, 0, '0, 0);
    do_req("t6 i1 t2", 0, addr_of(2, 1), 0, 0, '0, 0);
    do_req("t6 i2 t4", 0, addr_of(4, 2), 0, 0, '0, 0);
    do_req("t6 i2 t3 hit", 0, addr_of(3, 2), 1, 0, '0, 0);
    do_req("t6 i2 t0 evicted", 0, addr_of(0, 2), 0, 0, '0, 0);
    check_cnt("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
